// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch
// Purpose  : Fetch stage feeding instruction_decoder. Holds the PC, fetches
//            one word at a time from instruction memory over a req/ack
//            handshake, and presents it on instr_data/instr_pc/instr_en until
//            the decoder takes it. Redirects squash in-flight or held words.
// Ports    : clk, rst             - clock, synchronous active-high reset
//            imem_req/imem_addr   - memory request and word address (out)
//            imem_ack/imem_rdata  - one-cycle ack and its data (in)
//            instr_data/instr_pc  - fetched word and its PC (out)
//            instr_en             - instr_data/instr_pc valid (out)
//            instr_ready          - decoder accepts (in)
//            redirect_valid/_pc   - one-cycle redirect strobe and target (in)
// Revision : 1.0  initial release
// ============================================================================
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic        instr_en,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        squash_q, squash_d;
  logic        imem_req_q, imem_req_d;
  logic [31:0] imem_addr_q, imem_addr_d;
  logic        instr_en_q, instr_en_d;
  logic [31:0] instr_data_q, instr_data_d;
  logic [31:0] instr_pc_q, instr_pc_d;

  // Redirect targets are word aligned; low bits are simply dropped.
  logic [31:0] redir_target;
  assign redir_target = {redirect_pc[31:2], 2'b00};

  // Address to use when a squashed ack returns: a redirect arriving in the
  // same cycle wins, otherwise the pc already loaded by an earlier redirect.
  logic [31:0] resume_pc;
  assign resume_pc = redirect_valid ? redir_target : pc_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    squash_d     = squash_q;
    imem_req_d   = imem_req_q;
    imem_addr_d  = imem_addr_q;
    instr_en_d   = instr_en_q;
    instr_data_d = instr_data_q;
    instr_pc_d   = instr_pc_q;

    case (state_q)
      ST_IDLE: begin
        pc_d        = resume_pc;
        state_d     = ST_REQ;
        imem_req_d  = 1'b1;
        imem_addr_d = resume_pc;
      end

      ST_REQ: begin
        if (imem_ack) begin
          if (!squash_q && !redirect_valid) begin
            instr_data_d = imem_rdata;
            instr_pc_d   = imem_addr_q;
            instr_en_d   = 1'b1;
            pc_d         = pc_q + 32'd4;
            imem_req_d   = 1'b0;
            state_d      = ST_HOLD;
          end else begin
            // Stale response: drop it and reissue at the redirect target.
            squash_d    = 1'b0;
            pc_d        = resume_pc;
            imem_addr_d = resume_pc;
          end
        end else if (redirect_valid) begin
          // Request is still outstanding, so imem_addr must not move yet;
          // remember to throw away the response when it arrives.
          squash_d = 1'b1;
          pc_d     = redir_target;
        end
      end

      ST_HOLD: begin
        if (redirect_valid) begin
          instr_en_d  = 1'b0;
          pc_d        = redir_target;
          imem_req_d  = 1'b1;
          imem_addr_d = redir_target;
          state_d     = ST_REQ;
        end else if (instr_ready) begin
          instr_en_d  = 1'b0;
          imem_req_d  = 1'b1;
          imem_addr_d = pc_q;
          state_d     = ST_REQ;
        end
      end

      default: begin
        state_d    = ST_IDLE;
        imem_req_d = 1'b0;
        instr_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      squash_q     <= 1'b0;
      imem_req_q   <= 1'b0;
      imem_addr_q  <= RESET_PC;
      instr_en_q   <= 1'b0;
      instr_data_q <= 32'd0;
      instr_pc_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      squash_q     <= squash_d;
      imem_req_q   <= imem_req_d;
      imem_addr_q  <= imem_addr_d;
      instr_en_q   <= instr_en_d;
      instr_data_q <= instr_data_d;
      instr_pc_q   <= instr_pc_d;
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = imem_addr_q;
  assign instr_en   = instr_en_q;
  assign instr_data = instr_data_q;
  assign instr_pc   = instr_pc_q;

endmodule
`default_nettype wire
